ysyx_22040931_mp_regfile: RTL and testbench
===========================================

// Module: ysyx_22040931_mp_regfile
// PURPOSE
// - Multi-port general-purpose register file with write-to-read bypass and a per-register busy scoreboard.
// - Sits between decode (reads, issue marking) and writeback (NWR writeback ports) in the ysyx_22040931 core.
// - Replaces the single-write, two-read register file.
// - Also supports dual-issue and out-of-order writeback.
// PARAMETERS
// - DATA_W   64  register width in bits
// - ADDR_W   5   register index width; NREG = 2**ADDR_W
// - NRD      2   number of read ports (>=1)
// - NWR      2   number of write ports (>=1); a higher index has higher priority
// - BYPASS   1   1 = same-cycle write data is forwarded to reads; 0 = reads see only stored state
// - ZERO_REG 1   1 = reg 0 is hard-wired to 0 (writes and issues ignored, never busy)
// PORTS
// - clock     in   1            rising-edge clock
// - reset     in   1            asynchronous, active-low (0 = reset asserted)
// - wr_en     in   NWR          per-port write enable
// - wr_addr   in   NWR*ADDR_W   port k uses bits [k*ADDR_W +: ADDR_W]
// - wr_data   in   NWR*DATA_W   port k uses bits [k*DATA_W +: DATA_W]
// - rd_addr   in   NRD*ADDR_W   read addresses, packed as above
// - rd_data   out  NRD*DATA_W   read data, combinational
// - rd_busy   out  NRD          1 = the register addressed on that port has a pending producer
// - iss_en    in   1            mark iss_addr busy (an instruction issued that writes it)
// - iss_addr  in   ADDR_W       destination being issued
// - flush     in   1            clear the whole scoreboard (pipeline flush); register data untouched
// - busy_cnt  out  ADDR_W+1     number of registers currently busy (registered)
// BEHAVIOUR
// - Reset (reset==0, async): all NREG regs = 0, all busy bits = 0, busy_cnt = 0.
//   - rd_data then reads 0; rd_busy = 0.
//   - Release is synchronous to clock via the normal flops.
// - Write: at posedge, for each k with wr_en[k], regs[wr_addr_k] <= wr_data_k.
//   - Same-address conflict between ports: highest k wins.
//   - ZERO_REG=1: writes to addr 0 are dropped.
// - Read: rd_data_j = regs[rd_addr_j] combinationally, zero-latency.
//   - BYPASS=1: if any enabled write port targets rd_addr_j this cycle, use the highest such port's wr_data instead.
//   - ZERO_REG=1: addr 0 always reads 0, even with a write or bypass pending.
// - Scoreboard, one busy bit per register, updated at posedge:
//   - Clear: any enabled write port with wr_addr==a clears busy[a].
//   - Set: iss_en with iss_addr==a sets busy[a]. Set beats clear on the same address in the same cycle (a new producer is issued).
//   - Flush: flush=1 clears every busy bit. Flush beats set and clear; the iss_en in a flush cycle is discarded.
//   - ZERO_REG=1: busy[0] is constant 0.
//   - Re-issue to an already busy register keeps it busy; no error is flagged.
// - rd_busy_j = busy[rd_addr_j], except when BYPASS=1 and an enabled write to rd_addr_j occurs this cycle:
//   - In that case rd_busy_j = 0, because the data is forwarded.
//   - BYPASS=0: rd_busy_j = busy[rd_addr_j], unmodified.
// - busy_cnt is a register and always equals popcount(busy) of the current flops.
//   - Update it incrementally: +1 per newly set bit, -1 per newly cleared bit. Its next value equals the popcount of the next busy vector.
//   - Never wraps; the max is NREG (or NREG-1 when ZERO_REG=1), so ADDR_W+1 bits suffice.
//   - flush sets the next busy_cnt to 0.
// - Reset mid-operation: state is cleared immediately. In-flight writes in that cycle are lost.
// - Simulation only: export the register array through the existing set_gpr_ptr DPI hook at initial time.
// TESTING
// - Reset: drive reset=0 with random writes active, then release -> every read returns 0, rd_busy=0, busy_cnt=0.
// - Write/read: wr0 addr5=0xDEAD_BEEF; next cycle rd0 addr5 -> 0xDEAD_BEEF.
//   - Same cycle with BYPASS=1 -> 0xDEAD_BEEF; with BYPASS=0 -> the old value 0.
// - Port conflict: wr0 and wr1 both to addr7 (0x11 / 0x22) -> addr7 holds 0x22; the bypass read in that cycle gives 0x22.
// - x0: write 0x55 to addr0 and issue addr0 -> rd addr0 = 0, rd_busy = 0, busy_cnt unchanged.
// - Scoreboard: issue addr3 and addr4 -> busy_cnt=2.
//   - Next cycle, wr addr3 and iss addr3 together -> addr3 stays busy, busy_cnt=2.
//   - Then wr addr4 -> busy_cnt=1; rd addr4 rd_busy=0 in the write cycle.
// - Flush: with 10 registers busy, assert flush together with iss_en addr9 -> all busy=0, busy_cnt=0.
//   - Register contents are unchanged.

Source files
------------

// File: rtl/ysyx_22040931_mp_regfile.sv
// ysyx_22040931_mp_regfile
// Multi-port general-purpose register file with write-to-read bypass and a
// per-register busy scoreboard. It sits between decode, which reads operands
// and marks destinations busy, and writeback, which drives NWR write ports.
//
// Ports
//   clock     rising-edge clock
//   reset     asynchronous, active-low
//   wr_en     [NWR]          per-port write enable (higher port index wins)
//   wr_addr   [NWR*ADDR_W]   port k uses [k*ADDR_W +: ADDR_W]
//   wr_data   [NWR*DATA_W]   port k uses [k*DATA_W +: DATA_W]
//   rd_addr   [NRD*ADDR_W]   read addresses, packed the same way
//   rd_data   [NRD*DATA_W]   combinational read data
//   rd_busy   [NRD]          addressed register still has a pending producer
//   iss_en    mark iss_addr busy
//   iss_addr  [ADDR_W]       destination being issued
//   flush     clear the whole scoreboard; register data is kept
//   busy_cnt  [ADDR_W+1]     registered count of busy registers
//
// Interface timing: there is no valid/ready handshake. Every enable (wr_en,
// iss_en, flush) is a level-qualified request that takes effect at the next
// rising clock edge; read ports are pure combinational lookups.
module ysyx_22040931_mp_regfile #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic                  flush,
  output logic [ADDR_W:0]       busy_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic [ADDR_W:0]   busy_cnt_nxt;
  logic [ADDR_W:0]   inc_cnt;
  logic [ADDR_W:0]   dec_cnt;
  logic              iss_ok;

  // Issue to the hard-wired zero register is ignored entirely.
  assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

  // ------------------------------------------------------------------
  // Register array: later ports are applied last, so they win conflicts.
  // ------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_en[k] &&
            !((ZERO_REG != 0) && (wr_addr[k*ADDR_W +: ADDR_W] == '0))) begin
          regs[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Scoreboard next state. Priority, lowest to highest: write clears,
  // issue sets (a new producer replaces the finishing one), flush clears.
  // ------------------------------------------------------------------
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < NWR; k++) begin
      if (wr_en[k]) begin
        busy_nxt[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (iss_ok) begin
      busy_nxt[iss_addr] = 1'b1;
    end
    if (flush) begin
      busy_nxt = '0;
    end
    if (ZERO_REG != 0) begin
      busy_nxt[0] = 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Incremental busy count. A bit is newly set only by an issue to an idle
  // register; a bit is newly cleared by a write to a busy register that is
  // not re-issued this cycle. Several ports writing the same address clear
  // it once, so only the highest such port is counted.
  // ------------------------------------------------------------------
  always_comb begin
    inc_cnt = '0;
    dec_cnt = '0;
    if (iss_ok && !busy[iss_addr]) begin
      inc_cnt = (ADDR_W+1)'(1);
    end
    for (int k = 0; k < NWR; k++) begin
      logic dup;
      dup = 1'b0;
      for (int j = k + 1; j < NWR; j++) begin
        if (wr_en[j] &&
            (wr_addr[j*ADDR_W +: ADDR_W] == wr_addr[k*ADDR_W +: ADDR_W])) begin
          dup = 1'b1;
        end
      end
      if (wr_en[k] && !dup && busy[wr_addr[k*ADDR_W +: ADDR_W]] &&
          !(iss_ok && (iss_addr == wr_addr[k*ADDR_W +: ADDR_W]))) begin
        dec_cnt = dec_cnt + (ADDR_W+1)'(1);
      end
    end
    busy_cnt_nxt = flush ? '0 : (busy_cnt + inc_cnt - dec_cnt);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt_nxt;
    end
  end

  // ------------------------------------------------------------------
  // Read ports. Forwarded data implies the producer has completed, so the
  // busy flag is dropped with it. Forwarding is suppressed while reset is
  // asserted so that reads return the cleared state.
  // ------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int j = 0; j < NRD; j++) begin
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] d;
      logic              b;
      ra = rd_addr[j*ADDR_W +: ADDR_W];
      d  = regs[ra];
      b  = busy[ra];
      if ((BYPASS != 0) && reset) begin
        for (int k = 0; k < NWR; k++) begin
          if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == ra)) begin
            d = wr_data[k*DATA_W +: DATA_W];
            b = 1'b0;
          end
        end
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        d = '0;
        b = 1'b0;
      end
      rd_data[j*DATA_W +: DATA_W] = d;
      rd_busy[j]                  = b;
    end
  end

endmodule

// File: tb/tb_ysyx_22040931_mp_regfile.sv
module tb_ysyx_22040931_mp_regfile;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;
  localparam int NWR    = 2;

  // Output selectors used by the scoreboard.
  localparam int S_RD0    = 0;
  localparam int S_RD1    = 1;
  localparam int S_BUSY0  = 2;
  localparam int S_BUSY1  = 3;
  localparam int S_CNT    = 4;
  localparam int S_NB_RD0 = 5;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [NWR-1:0]        wr_en;
  logic [NWR*ADDR_W-1:0] wr_addr;
  logic [NWR*DATA_W-1:0] wr_data;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;
  logic                  flush;
  logic [ADDR_W:0]       busy_cnt;

  // Second instance without forwarding, shares all inputs.
  logic [NRD*DATA_W-1:0] nb_rd_data;
  logic [NRD-1:0]        nb_rd_busy;
  logic [ADDR_W:0]       nb_busy_cnt;

  ysyx_22040931_mp_regfile #(.BYPASS(1)) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .busy_cnt(busy_cnt)
  );

  ysyx_22040931_mp_regfile #(.BYPASS(0)) dut_nb (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .busy_cnt(nb_busy_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int          sel_q[$];
  string       nm_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic expect_val(input int sel, input logic [63:0] val, input string nm);
    exp_q.push_back(val);
    sel_q.push_back(sel);
    nm_q.push_back(nm);
  endtask

  // Monitor: the DUT presents its outputs combinationally / from flops, so
  // every queued expectation is checked mid-cycle, away from the edge.
  always @(negedge clock) begin
    while (exp_q.size() > 0) begin
      logic [63:0] e;
      logic [63:0] act;
      int          s;
      string       n;
      e   = exp_q.pop_front();
      s   = sel_q.pop_front();
      n   = nm_q.pop_front();
      act = '0;
      case (s)
        S_RD0:    act = rd_data[63:0];
        S_RD1:    act = rd_data[127:64];
        S_BUSY0:  act = {63'b0, rd_busy[0]};
        S_BUSY1:  act = {63'b0, rd_busy[1]};
        S_CNT:    act = {58'b0, busy_cnt};
        S_NB_RD0: act = nb_rd_data[63:0];
        default:  act = 'x;
      endcase
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", n, act, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
    flush    = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int k, input int a, input logic [63:0] d);
    wr_en[k]                    = 1'b1;
    wr_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
    wr_data[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic iss(input int a);
    iss_en   = 1'b1;
    iss_addr = ADDR_W'(a);
  endtask

  task automatic rd(input int j, input int a);
    rd_addr[j*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int reset_addrs[4] = '{1, 5, 7, 31};
    idle();
    rd_addr = '0;
    #2 reset = 1'b0;
    // Random writes and issues while reset is held must leave no trace.
    for (int i = 0; i < 4; i++) begin
      wr_en    = 2'b11;
      wr_addr  = 10'($urandom_range(0, 1023));
      wr_data  = {$urandom, $urandom, $urandom, $urandom};
      iss_en   = 1'b1;
      iss_addr = 5'($urandom_range(0, 31));
      step();
    end
    idle();
    step();
    reset = 1'b1;
    step();

    foreach (reset_addrs[i]) begin
      rd(0, reset_addrs[i]);
      rd(1, 31 - reset_addrs[i]);
      expect_val(S_RD0, 64'h0, "reset_rd0");
      expect_val(S_RD1, 64'h0, "reset_rd1");
      expect_val(S_BUSY0, 64'h0, "reset_busy0");
      expect_val(S_BUSY1, 64'h0, "reset_busy1");
      expect_val(S_CNT, 64'h0, "reset_cnt");
      step();
    end

    // Write / read with and without forwarding.
    wr(0, 5, 64'hDEAD_BEEF);
    rd(0, 5);
    rd(1, 5);
    expect_val(S_RD0, 64'hDEAD_BEEF, "bypass_same_cycle");
    expect_val(S_NB_RD0, 64'h0, "nobypass_same_cycle");
    step();
    idle();
    expect_val(S_RD0, 64'hDEAD_BEEF, "read_after_write");
    expect_val(S_NB_RD0, 64'hDEAD_BEEF, "nb_read_after_write");
    step();

    // Port conflict: higher port wins.
    wr(0, 7, 64'h11);
    wr(1, 7, 64'h22);
    rd(0, 7);
    expect_val(S_RD0, 64'h22, "conflict_bypass");
    expect_val(S_NB_RD0, 64'h0, "conflict_nb_old");
    step();
    idle();
    expect_val(S_RD0, 64'h22, "conflict_stored");
    expect_val(S_NB_RD0, 64'h22, "conflict_nb_stored");
    step();

    // Register 0 is hard-wired.
    wr(0, 0, 64'h55);
    iss(0);
    rd(0, 0);
    expect_val(S_RD0, 64'h0, "x0_bypass");
    expect_val(S_BUSY0, 64'h0, "x0_busy");
    expect_val(S_CNT, 64'h0, "x0_cnt");
    step();
    idle();
    expect_val(S_RD0, 64'h0, "x0_stored");
    expect_val(S_BUSY0, 64'h0, "x0_busy_after");
    expect_val(S_CNT, 64'h0, "x0_cnt_after");
    step();

    // Scoreboard set/clear.
    iss(3);
    expect_val(S_CNT, 64'd0, "sb_cnt_a");
    step();
    idle();
    iss(4);
    rd(0, 3);
    expect_val(S_CNT, 64'd1, "sb_cnt_b");
    expect_val(S_BUSY0, 64'd1, "sb_busy3");
    step();
    idle();
    wr(0, 3, 64'h33);
    iss(3);
    rd(0, 4);
    rd(1, 3);
    expect_val(S_CNT, 64'd2, "sb_cnt_c");
    expect_val(S_BUSY0, 64'd1, "sb_busy4");
    expect_val(S_BUSY1, 64'd0, "sb_busy3_fwd");
    step();
    idle();
    wr(0, 4, 64'h44);
    expect_val(S_CNT, 64'd2, "sb_reissue_cnt");
    expect_val(S_BUSY0, 64'd0, "sb_busy4_wr_cycle");
    expect_val(S_BUSY1, 64'd1, "sb_busy3_reissued");
    step();
    idle();
    expect_val(S_CNT, 64'd1, "sb_cnt_after_wr4");
    expect_val(S_BUSY0, 64'd0, "sb_busy4_clear");
    expect_val(S_BUSY1, 64'd1, "sb_busy3_still");
    step();

    // Fill to 10 busy registers (3 plus 10..18).
    for (int r = 10; r <= 18; r++) begin
      idle();
      iss(r);
      expect_val(S_CNT, 64'(r - 9), "fill_cnt");
      step();
    end
    idle();
    rd(0, 9);
    rd(1, 10);
    expect_val(S_CNT, 64'd10, "fill_cnt_10");
    // Flush together with an issue: the issue is discarded.
    flush = 1'b1;
    iss(9);
    expect_val(S_BUSY0, 64'd0, "flush_cycle_busy9");
    expect_val(S_BUSY1, 64'd1, "flush_cycle_busy10");
    step();
    idle();
    rd(0, 9);
    rd(1, 3);
    expect_val(S_CNT, 64'd0, "flush_cnt");
    expect_val(S_BUSY0, 64'd0, "flush_busy9");
    expect_val(S_BUSY1, 64'd0, "flush_busy3");
    step();
    rd(0, 5);
    rd(1, 7);
    expect_val(S_RD0, 64'hDEAD_BEEF, "flush_keep5");
    expect_val(S_RD1, 64'h22, "flush_keep7");
    step();
    rd(0, 3);
    rd(1, 4);
    expect_val(S_RD0, 64'h33, "flush_keep3");
    expect_val(S_RD1, 64'h44, "flush_keep4");
    step();

    // Two ports writing one busy register clear it once.
    iss(20);
    step();
    idle();
    iss(21);
    step();
    idle();
    wr(0, 20, 64'hA0);
    wr(1, 20, 64'hA1);
    expect_val(S_CNT, 64'd2, "dup_cnt_before");
    step();
    idle();
    wr(0, 21, 64'hB0);
    wr(1, 22, 64'hB1);
    expect_val(S_CNT, 64'd1, "dup_cnt_once");
    step();
    idle();
    rd(0, 20);
    expect_val(S_CNT, 64'd0, "two_port_clear_cnt");
    expect_val(S_RD0, 64'hA1, "dup_data");
    step();

    // Re-issue to a busy register is idempotent.
    iss(25);
    step();
    iss(25);
    expect_val(S_CNT, 64'd1, "reissue_cnt_a");
    step();
    idle();
    expect_val(S_CNT, 64'd1, "reissue_cnt_b");
    step();

    // Reset mid-operation clears state immediately.
    reset = 1'b0;
    rd(0, 5);
    rd(1, 25);
    expect_val(S_CNT, 64'd0, "midreset_cnt");
    expect_val(S_RD0, 64'h0, "midreset_rd5");
    expect_val(S_BUSY1, 64'd0, "midreset_busy25");
    step();
    reset = 1'b1;
    step();
    expect_val(S_RD0, 64'h0, "postreset_rd5");
    step();

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
